fifo_rd_dnconv: RTL and testbench

- Drain stage sitting directly downstream of the team's synchronous FIFO.
- The FIFO has show-ahead reads: its read data is valid whenever it is not empty, and its read strobe pops the current word.
- This block pops DWID-wide words and emits each one as DWID/OWID narrower slices on a valid/ready stream. It serves a narrower consumer such as a byte-lane serializer or bus bridge.
- It runs at full rate: one slice per cycle while the sink is ready, with no bubble between words.

---
 rtl/fifo_rd_dnconv.sv | 137 +++++++++++++
 tb/tb_fifo_rd_dnconv.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_dnconv.sv
// Show-ahead FIFO drain stage: pops DWID-bit words and emits them as OWID-bit
// slices on a valid/ready stream. Define DNCONV_MSB_FIRST_EN for MSB-first slice order.
module fifo_rd_dnconv #(
  parameter int DWID = 16,
  parameter int OWID = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fifo_empty_i,
  input  logic [DWID-1:0] fifo_rdata_i,
  output logic            fifo_rd_o,
  output logic            m_valid_o,
  input  logic            m_ready_i,
  output logic [OWID-1:0] m_data_o,
  output logic            m_last_o,
  output logic            busy_o,
  output logic [15:0]     word_cnt_o
);

  localparam int RATIO = DWID / OWID;
  localparam int CWID  = (RATIO > 1) ? $clog2(RATIO) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  localparam logic [CWID-1:0] LAST_CNT = CWID'(RATIO - 1);

  logic [0:0]      state_r;
  logic [DWID-1:0] shift_r;
  logic [CWID-1:0] cnt_r;
  logic            last_r;
  logic            run_r;
  logic [15:0]     word_cnt_r;
  logic            pop_s;
  logic            hs_s;

  // Move the next slice into the output position of the shift register.
  function automatic logic [DWID-1:0] advance(input logic [DWID-1:0] word);
`ifdef DNCONV_MSB_FIRST_EN
    return word << OWID;
`else
    return word >> OWID;
`endif
  endfunction

  // Pop and handshake decode; the only combinational input-to-output path.
  always_comb begin
    pop_s = 1'b0;
    hs_s  = 1'b0;
    case (state_r)
      IDLE: begin
        // run_r keeps the pop strobe low until the first edge after reset release
        pop_s = run_r & ~fifo_empty_i;
        hs_s  = 1'b0;
      end
      SEND: begin
        hs_s  = m_ready_i;
        pop_s = m_ready_i & last_r & ~fifo_empty_i;
      end
      default: begin
        pop_s = 1'b0;
        hs_s  = 1'b0;
      end
    endcase
  end

  // Out-of-reset qualifier for the pop strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_r <= 1'b0;
    end else begin
      run_r <= 1'b1;
    end
  end

  // Word load, slice sequencing and word counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      shift_r    <= {DWID{1'b0}};
      cnt_r      <= {CWID{1'b0}};
      last_r     <= 1'b0;
      word_cnt_r <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            shift_r <= fifo_rdata_i;
            cnt_r   <= {CWID{1'b0}};
            last_r  <= 1'b0;
            state_r <= SEND;
          end else begin
            state_r <= IDLE;
          end
        end
        SEND: begin
          if (!hs_s) begin
            state_r <= SEND;
          end else if (last_r) begin
            word_cnt_r <= word_cnt_r + 16'd1;
            cnt_r      <= {CWID{1'b0}};
            last_r     <= 1'b0;
            if (pop_s) begin
              shift_r <= fifo_rdata_i;
              state_r <= SEND;
            end else begin
              shift_r <= {DWID{1'b0}};
              state_r <= IDLE;
            end
          end else begin
            shift_r <= advance(shift_r);
            cnt_r   <= cnt_r + CWID'(1);
            last_r  <= ((cnt_r + CWID'(1)) == LAST_CNT);
          end
        end
        default: begin
          state_r <= IDLE;
          shift_r <= {DWID{1'b0}};
          cnt_r   <= {CWID{1'b0}};
          last_r  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_rd_o  = pop_s;
  assign m_valid_o  = (state_r == SEND);
  assign busy_o     = (state_r == SEND);
  assign m_last_o   = last_r;
  assign word_cnt_o = word_cnt_r;
`ifdef DNCONV_MSB_FIRST_EN
  assign m_data_o   = shift_r[DWID-1 -: OWID];
`else
  assign m_data_o   = shift_r[OWID-1:0];
`endif

endmodule

// File: tb/tb_fifo_rd_dnconv.sv
// Directed table-driven bench for fifo_rd_dnconv (DWID=16, OWID=4).
module tb_fifo_rd_dnconv;

  logic        clk;
  logic        rst;
  logic        fifo_empty_i;
  logic [15:0] fifo_rdata_i;
  logic        fifo_rd_o;
  logic        m_valid_o;
  logic        m_ready_i;
  logic [3:0]  m_data_o;
  logic        m_last_o;
  logic        busy_o;
  logic [15:0] word_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_rd_dnconv #(.DWID(16), .OWID(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rdata_i (fifo_rdata_i),
    .fifo_rd_o    (fifo_rd_o),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .m_data_o     (m_data_o),
    .m_last_o     (m_last_o),
    .busy_o       (busy_o),
    .word_cnt_o   (word_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        empty;
    logic [15:0] rdata;
    logic        ready;
    logic        exp_rd;
    logic        exp_valid;
    logic [3:0]  exp_data;
    logic        exp_last;
    logic        exp_busy;
    logic [15:0] exp_wcnt;
  } vec_t;

  vec_t vt[64];
  int   nv = 0;

  // Slice k of a word in the order the build emits them.
  function automatic logic [3:0] sl(input logic [15:0] w, input int k);
`ifdef DNCONV_MSB_FIRST_EN
    return w[15 - k*4 -: 4];
`else
    return w[k*4 +: 4];
`endif
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic add(input logic e, input logic [15:0] d, input logic r, input logic rd,
                     input logic v, input logic [3:0] dat, input logic l, input logic b,
                     input logic [15:0] wc);
    vt[nv] = '{e, d, r, rd, v, dat, l, b, wc};
    nv++;
  endtask

  // Drive one vector at the falling edge and check just after it.
  task automatic apply(input vec_t x);
    @(negedge clk);
    fifo_empty_i = x.empty;
    fifo_rdata_i = x.rdata;
    m_ready_i    = x.ready;
    #1;
    chk("fifo_rd", {15'd0, fifo_rd_o}, {15'd0, x.exp_rd});
    chk("m_valid", {15'd0, m_valid_o}, {15'd0, x.exp_valid});
    chk("busy", {15'd0, busy_o}, {15'd0, x.exp_busy});
    chk("word_cnt", word_cnt_o, x.exp_wcnt);
    if (x.exp_valid) begin
      chk("m_data", {12'd0, m_data_o}, {12'd0, x.exp_data});
      chk("m_last", {15'd0, m_last_o}, {15'd0, x.exp_last});
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rd"}, {15'd0, fifo_rd_o}, 16'd0);
    chk({tag, "_valid"}, {15'd0, m_valid_o}, 16'd0);
    chk({tag, "_busy"}, {15'd0, busy_o}, 16'd0);
    chk({tag, "_last"}, {15'd0, m_last_o}, 16'd0);
    chk({tag, "_wcnt"}, word_cnt_o, 16'd0);
  endtask

  initial begin
    rst          = 1'b0;
    fifo_empty_i = 1'b1;
    fifo_rdata_i = 16'h0000;
    m_ready_i    = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) add(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 16'd0);
    // Single word 0xA5C3 (LSB-first: 3,C,5,A)
    add(1'b0, 16'hA5C3, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 16'd0);
    add(1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, sl(16'hA5C3, 0), 1'b0, 1'b1, 16'd0);
    add(1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, sl(16'hA5C3, 1), 1'b0, 1'b1, 16'd0);
    add(1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, sl(16'hA5C3, 2), 1'b0, 1'b1, 16'd0);
    add(1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, sl(16'hA5C3, 3), 1'b1, 1'b1, 16'd0);
    add(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 16'd1);
    // Back-to-back 0x1234 then 0xBEEF, second pop on last-slice handshake
    add(1'b0, 16'h1234, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 16'd1);
    add(1'b0, 16'hBEEF, 1'b1, 1'b0, 1'b1, sl(16'h1234, 0), 1'b0, 1'b1, 16'd1);
    add(1'b0, 16'hBEEF, 1'b1, 1'b0, 1'b1, sl(16'h1234, 1), 1'b0, 1'b1, 16'd1);
    add(1'b0, 16'hBEEF, 1'b1, 1'b0, 1'b1, sl(16'h1234, 2), 1'b0, 1'b1, 16'd1);
    add(1'b0, 16'hBEEF, 1'b1, 1'b1, 1'b1, sl(16'h1234, 3), 1'b1, 1'b1, 16'd1);
    add(1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, sl(16'hBEEF, 0), 1'b0, 1'b1, 16'd2);
    add(1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, sl(16'hBEEF, 1), 1'b0, 1'b1, 16'd2);
    add(1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, sl(16'hBEEF, 2), 1'b0, 1'b1, 16'd2);
    add(1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, sl(16'hBEEF, 3), 1'b1, 1'b1, 16'd2);
    add(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 16'd3);
    // Backpressure on 0x00F0, ready 1,0,0,1,1,0,1
    add(1'b0, 16'h00F0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 16'd3);
    add(1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, sl(16'h00F0, 0), 1'b0, 1'b1, 16'd3);
    add(1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, sl(16'h00F0, 1), 1'b0, 1'b1, 16'd3);
    add(1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, sl(16'h00F0, 1), 1'b0, 1'b1, 16'd3);
    add(1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, sl(16'h00F0, 1), 1'b0, 1'b1, 16'd3);
    add(1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, sl(16'h00F0, 2), 1'b0, 1'b1, 16'd3);
    add(1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, sl(16'h00F0, 3), 1'b1, 1'b1, 16'd3);
    add(1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, sl(16'h00F0, 3), 1'b1, 1'b1, 16'd3);
    // Empty at boundary, FIFO refills two cycles later
    add(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 16'd4);
    add(1'b0, 16'h9876, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 16'd4);
    add(1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, sl(16'h9876, 0), 1'b0, 1'b1, 16'd4);
    add(1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, sl(16'h9876, 1), 1'b0, 1'b1, 16'd4);
    add(1'b0, 16'h4321, 1'b1, 1'b0, 1'b1, sl(16'h9876, 2), 1'b0, 1'b1, 16'd4);
    // Stalled on the last slice with data waiting: no pop until the handshake
    add(1'b0, 16'h4321, 1'b0, 1'b0, 1'b1, sl(16'h9876, 3), 1'b1, 1'b1, 16'd4);
    add(1'b0, 16'h4321, 1'b1, 1'b1, 1'b1, sl(16'h9876, 3), 1'b1, 1'b1, 16'd4);
    add(1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, sl(16'h4321, 0), 1'b0, 1'b1, 16'd5);
    add(1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, sl(16'h4321, 1), 1'b0, 1'b1, 16'd5);
    add(1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, sl(16'h4321, 2), 1'b0, 1'b1, 16'd5);
    add(1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, sl(16'h4321, 3), 1'b1, 1'b1, 16'd5);
    add(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 16'd6);

    // Reset held for 3 cycles with a non-empty FIFO: nothing may move
    fifo_empty_i = 1'b0;
    fifo_rdata_i = 16'h1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk_quiet("reset");
    end
    @(negedge clk);
    fifo_empty_i = 1'b1;
    rst          = 1'b1;

    for (int i = 0; i < nv; i++) apply(vt[i]);

    // Literal check of the first word's slice order
`ifdef DNCONV_MSB_FIRST_EN
    chk("order_lit0", {12'd0, sl(16'hA5C3, 0)}, 16'h000A);
`else
    chk("order_lit0", {12'd0, sl(16'hA5C3, 0)}, 16'h0003);
`endif

    // Reset mid-word after two of four slices of 0xA5C3
    apply('{1'b0, 16'hA5C3, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 16'd6});
    apply('{1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, sl(16'hA5C3, 0), 1'b0, 1'b1, 16'd6});
    apply('{1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, sl(16'hA5C3, 1), 1'b0, 1'b1, 16'd6});
    @(negedge clk);
    #1;
    chk("pre_rst_valid", {15'd0, m_valid_o}, 16'd1);
    fifo_empty_i = 1'b0;
    fifo_rdata_i = 16'h0001;
    rst          = 1'b0;
    #1;
    chk_quiet("midrst");
    @(negedge clk);
    #1;
    chk_quiet("midrst_hold");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_quiet("release");
    apply('{1'b0, 16'h0001, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 16'd0});
    for (int k = 0; k < 4; k++)
      apply('{1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, sl(16'h0001, k), (k == 3), 1'b1, 16'd0});
    apply('{1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 16'd1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
